// File: rtl/hilo_unit.sv
// hilo_unit: multi-cycle HI/LO result unit; models MULT/DIV latency with a busy counter.
// Optional feature macro HILO_BYPASS_EN: MFHI/MFLO served from the pending result on the commit cycle.
module hilo_unit #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 12
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_HILO_VALID,
    input  logic [11:0] IN_HILO_CTRL,
    input  logic [63:0] IN_HILO_ALU64,
    input  logic [31:0] IN_HILO_DIVISOR,
    output logic [31:0] OUT_HILO_32,
    output logic        OUT_HILO_STALL,
    output logic        OUT_HILO_BUSY,
    output logic [31:0] OUT_HILO_HI,
    output logic [31:0] OUT_HILO_LO,
    output logic        OUT_HILO_DIVZ
);

    localparam logic [11:0] CODE_MULT = 12'h0D8;
    localparam logic [11:0] CODE_DIV  = 12'h0DA;
    localparam logic [11:0] CODE_MFHI = 12'h0D0;
    localparam logic [11:0] CODE_MFLO = 12'h0D2;
    localparam logic [7:0]  MUL_CNT   = 8'(MUL_LAT);
    localparam logic [7:0]  DIV_CNT   = 8'(DIV_LAT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [63:0] pending;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divz;

    logic is_mult;
    logic is_div;
    logic is_mfhi;
    logic is_mflo;
    logic is_move;
    logic last_cycle;
    logic bypass_ok;

    assign is_mult    = IN_HILO_VALID && (IN_HILO_CTRL == CODE_MULT);
    assign is_div     = IN_HILO_VALID && (IN_HILO_CTRL == CODE_DIV);
    assign is_mfhi    = IN_HILO_VALID && (IN_HILO_CTRL == CODE_MFHI);
    assign is_mflo    = IN_HILO_VALID && (IN_HILO_CTRL == CODE_MFLO);
    assign is_move    = is_mfhi || is_mflo;
    assign last_cycle = (state == ST_BUSY) && (cnt == 8'd1);

`ifdef HILO_BYPASS_EN
    assign bypass_ok = last_cycle;
`else
    assign bypass_ok = 1'b0;
`endif

    // Reads are never served mid-flight except the optional commit-cycle bypass.
    always_comb begin
        OUT_HILO_STALL = 1'b0;
        OUT_HILO_32    = '0;
        if (state == ST_IDLE) begin
            if (is_mfhi) begin
                OUT_HILO_32 = hi;
            end else if (is_mflo) begin
                OUT_HILO_32 = lo;
            end
        end else if (is_move && bypass_ok) begin
            OUT_HILO_32 = is_mfhi ? pending[63:32] : pending[31:0];
        end else if (is_move || is_mult || is_div) begin
            OUT_HILO_STALL = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pending <= '0;
            hi      <= '0;
            lo      <= '0;
            divz    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_mult) begin
                        pending <= IN_HILO_ALU64;
                        cnt     <= MUL_CNT;
                        state   <= ST_BUSY;
                    end else if (is_div) begin
                        // A zero divisor is flagged and dropped without touching HI/LO.
                        if (IN_HILO_DIVISOR == 32'd0) begin
                            divz <= 1'b1;
                        end else begin
                            pending <= IN_HILO_ALU64;
                            cnt     <= DIV_CNT;
                            state   <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - 8'd1;
                    if (last_cycle) begin
                        hi    <= pending[63:32];
                        lo    <= pending[31:0];
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign OUT_HILO_BUSY = (state == ST_BUSY);
    assign OUT_HILO_HI   = hi;
    assign OUT_HILO_LO   = lo;
    assign OUT_HILO_DIVZ = divz;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: self-checking bench for hilo_unit against a timeline-based reference model.
// Follows HILO_BYPASS_EN the same way the design does.
module tb_hilo_unit;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 12;
    localparam logic [11:0] C_MULT = 12'h0D8;
    localparam logic [11:0] C_DIV  = 12'h0DA;
    localparam logic [11:0] C_MFHI = 12'h0D0;
    localparam logic [11:0] C_MFLO = 12'h0D2;
`ifdef HILO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_HILO_VALID;
    logic [11:0] IN_HILO_CTRL;
    logic [63:0] IN_HILO_ALU64;
    logic [31:0] IN_HILO_DIVISOR;
    logic [31:0] OUT_HILO_32;
    logic        OUT_HILO_STALL;
    logic        OUT_HILO_BUSY;
    logic [31:0] OUT_HILO_HI;
    logic [31:0] OUT_HILO_LO;
    logic        OUT_HILO_DIVZ;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edges taken so far, edge at which the in-flight result commits.
    int          t_edge;
    int          commit_edge;
    logic [63:0] m_pend;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_divz;
    logic        exp_busy;
    logic        exp_stall;
    logic [31:0] exp_out;

    hilo_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .CLK(CLK), .RST(RST),
        .IN_HILO_VALID(IN_HILO_VALID), .IN_HILO_CTRL(IN_HILO_CTRL),
        .IN_HILO_ALU64(IN_HILO_ALU64), .IN_HILO_DIVISOR(IN_HILO_DIVISOR),
        .OUT_HILO_32(OUT_HILO_32), .OUT_HILO_STALL(OUT_HILO_STALL),
        .OUT_HILO_BUSY(OUT_HILO_BUSY), .OUT_HILO_HI(OUT_HILO_HI),
        .OUT_HILO_LO(OUT_HILO_LO), .OUT_HILO_DIVZ(OUT_HILO_DIVZ)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic v, input logic [11:0] c, input logic [63:0] a, input logic [31:0] d);
        IN_HILO_VALID   = v;
        IN_HILO_CTRL    = c;
        IN_HILO_ALU64   = a;
        IN_HILO_DIVISOR = d;
    endtask

    task automatic model_reset();
        commit_edge = 0;
        m_pend = '0;
        m_hi   = '0;
        m_lo   = '0;
        m_divz = 1'b0;
    endtask

    task automatic predict();
        bit busy, last, rd, ex, mfhi;
        busy = t_edge < commit_edge;
        last = busy && (t_edge == commit_edge - 1);
        mfhi = IN_HILO_VALID && (IN_HILO_CTRL == C_MFHI);
        rd   = mfhi || (IN_HILO_VALID && (IN_HILO_CTRL == C_MFLO));
        ex   = IN_HILO_VALID && ((IN_HILO_CTRL == C_MULT) || (IN_HILO_CTRL == C_DIV));
        exp_busy  = busy;
        exp_stall = 1'b0;
        exp_out   = '0;
        if (!busy) begin
            if (rd) exp_out = mfhi ? m_hi : m_lo;
        end else if (rd && BYP && last) begin
            exp_out = mfhi ? m_pend[63:32] : m_pend[31:0];
        end else begin
            exp_stall = rd || ex;
        end
    endtask

    task automatic tick();
        bit busy;
        busy = t_edge < commit_edge;
        @(posedge CLK);
        t_edge++;
        if (busy && t_edge == commit_edge) begin
            m_hi = m_pend[63:32];
            m_lo = m_pend[31:0];
        end else if (!busy && IN_HILO_VALID) begin
            if (IN_HILO_CTRL == C_MULT) begin
                m_pend = IN_HILO_ALU64;
                commit_edge = t_edge + MUL_LAT;
            end else if (IN_HILO_CTRL == C_DIV) begin
                if (IN_HILO_DIVISOR == 32'd0) begin
                    m_divz = 1'b1;
                end else begin
                    m_pend = IN_HILO_ALU64;
                    commit_edge = t_edge + DIV_LAT;
                end
            end
        end
        @(negedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive(1'b0, 12'h000, 64'h0, 32'h0);
        @(negedge CLK);
        #1;
        n_checks++;
        if ({OUT_HILO_BUSY, OUT_HILO_STALL, OUT_HILO_32, OUT_HILO_HI, OUT_HILO_LO, OUT_HILO_DIVZ} !== 99'b0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b stall=%b out=%h hi=%h lo=%h divz=%b, expected all zero",
                     OUT_HILO_BUSY, OUT_HILO_STALL, OUT_HILO_32, OUT_HILO_HI, OUT_HILO_LO, OUT_HILO_DIVZ);
        end
        RST = 1'b0;
        drive(1'b1, C_MFLO, 64'h0, 32'h0);
        #1;
        predict();
        n_checks++;
        if ({OUT_HILO_STALL, OUT_HILO_32} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_mflo: got stall=%b out=%h, expected stall=0 out=00000000", OUT_HILO_STALL, OUT_HILO_32);
        end
        tick();
        drive(1'b1, C_MFHI, 64'h0, 32'h0);
        #1;
        n_checks++;
        if ({OUT_HILO_STALL, OUT_HILO_32} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_mfhi: got stall=%b out=%h, expected stall=0 out=00000000", OUT_HILO_STALL, OUT_HILO_32);
        end
        tick();
    endtask

    task automatic test_mult_read();
        int stalls;
        drive(1'b1, C_MULT, 64'h00000002_00000003, 32'h0);
        #1;
        predict();
        n_checks++;
        if ({OUT_HILO_STALL, OUT_HILO_BUSY} !== {exp_stall, exp_busy}) begin
            n_fail++;
            $display("FAIL mult_accept: got stall=%b busy=%b, expected stall=%b busy=%b",
                     OUT_HILO_STALL, OUT_HILO_BUSY, exp_stall, exp_busy);
        end
        tick();
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, C_MFHI, 64'h0, 32'h0);
            #1;
            predict();
            n_checks++;
            if ({OUT_HILO_STALL, OUT_HILO_BUSY, OUT_HILO_32} !== {exp_stall, exp_busy, exp_out}) begin
                n_fail++;
                $display("FAIL mult_mfhi_cycle%0d: got stall=%b busy=%b out=%h, expected stall=%b busy=%b out=%h",
                         k, OUT_HILO_STALL, OUT_HILO_BUSY, OUT_HILO_32, exp_stall, exp_busy, exp_out);
            end
            if (!OUT_HILO_STALL) break;
            stalls++;
            tick();
        end
        n_checks++;
        if (stalls !== (BYP ? 3 : 4) || OUT_HILO_32 !== 32'h2) begin
            n_fail++;
            $display("FAIL mult_read: got stalls=%0d out=%h, expected stalls=%0d out=00000002",
                     stalls, OUT_HILO_32, BYP ? 3 : 4);
        end
        tick();
        n_checks++;
        if ({OUT_HILO_HI, OUT_HILO_LO, OUT_HILO_BUSY} !== {32'h2, 32'h3, 1'b0}) begin
            n_fail++;
            $display("FAIL mult_commit: got hi=%h lo=%h busy=%b, expected hi=00000002 lo=00000003 busy=0",
                     OUT_HILO_HI, OUT_HILO_LO, OUT_HILO_BUSY);
        end
    endtask

    task automatic test_div();
        drive(1'b1, C_DIV, 64'h00000002_00000003, 32'd5);
        #1;
        tick();
        for (int k = 0; k < DIV_LAT; k++) begin
            // counter reads DIV_LAT-k this cycle; issue the read at count 5
            if (DIV_LAT - k == 5) drive(1'b1, C_MFLO, 64'h0, 32'h0);
            else drive(1'b0, 12'h000, 64'h0, 32'h0);
            #1;
            predict();
            n_checks++;
            if ({OUT_HILO_STALL, OUT_HILO_BUSY, OUT_HILO_32} !== {exp_stall, exp_busy, exp_out}) begin
                n_fail++;
                $display("FAIL div_cycle%0d: got stall=%b busy=%b out=%h, expected stall=%b busy=%b out=%h",
                         k, OUT_HILO_STALL, OUT_HILO_BUSY, OUT_HILO_32, exp_stall, exp_busy, exp_out);
            end
            if (DIV_LAT - k == 5) begin
                n_checks++;
                if (OUT_HILO_STALL !== 1'b1) begin
                    n_fail++;
                    $display("FAIL div_mflo_cnt5: got stall=%b, expected stall=1", OUT_HILO_STALL);
                end
            end
            tick();
        end
        n_checks++;
        if ({OUT_HILO_HI, OUT_HILO_LO, OUT_HILO_BUSY} !== {32'd2, 32'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL div_commit: got hi=%h lo=%h busy=%b, expected hi=00000002 lo=00000003 busy=0",
                     OUT_HILO_HI, OUT_HILO_LO, OUT_HILO_BUSY);
        end
    endtask

    task automatic test_divz();
        logic [31:0] hi0, lo0;
        hi0 = m_hi;
        lo0 = m_lo;
        drive(1'b1, C_DIV, 64'hDEAD_BEEF_1234_5678, 32'd0);
        #1;
        tick();
        n_checks++;
        if ({OUT_HILO_DIVZ, OUT_HILO_BUSY, OUT_HILO_HI, OUT_HILO_LO} !== {1'b1, 1'b0, hi0, lo0}) begin
            n_fail++;
            $display("FAIL divz_set: got divz=%b busy=%b hi=%h lo=%h, expected divz=1 busy=0 hi=%h lo=%h",
                     OUT_HILO_DIVZ, OUT_HILO_BUSY, OUT_HILO_HI, OUT_HILO_LO, hi0, lo0);
        end
        drive(1'b0, 12'h000, 64'h0, 32'h0);
        for (int k = 0; k < 3; k++) tick();
        n_checks++;
        if (OUT_HILO_DIVZ !== 1'b1) begin
            n_fail++;
            $display("FAIL divz_sticky: got divz=%b, expected divz=1", OUT_HILO_DIVZ);
        end
    endtask

    task automatic test_back_to_back();
        int stalls;
        drive(1'b1, C_MULT, 64'h00000005_00000006, 32'h0);
        #1;
        tick();
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, C_MULT, 64'h00000001_0000000F, 32'h0);
            #1;
            predict();
            n_checks++;
            if ({OUT_HILO_STALL, OUT_HILO_BUSY, OUT_HILO_HI, OUT_HILO_LO} !== {exp_stall, exp_busy, m_hi, m_lo}) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got stall=%b busy=%b hi=%h lo=%h, expected stall=%b busy=%b hi=%h lo=%h",
                         k, OUT_HILO_STALL, OUT_HILO_BUSY, OUT_HILO_HI, OUT_HILO_LO, exp_stall, exp_busy, m_hi, m_lo);
            end
            if (!OUT_HILO_STALL) break;
            stalls++;
            tick();
        end
        n_checks++;
        if (stalls !== MUL_LAT || {OUT_HILO_HI, OUT_HILO_LO} !== {32'h5, 32'h6}) begin
            n_fail++;
            $display("FAIL b2b_stall: got stalls=%0d hi=%h lo=%h, expected stalls=%0d hi=00000005 lo=00000006",
                     stalls, OUT_HILO_HI, OUT_HILO_LO, MUL_LAT);
        end
        tick();
        drive(1'b0, 12'h000, 64'h0, 32'h0);
        n_checks++;
        if (OUT_HILO_BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b, expected busy=1", OUT_HILO_BUSY);
        end
        for (int k = 0; k < MUL_LAT; k++) tick();
        n_checks++;
        if ({OUT_HILO_HI, OUT_HILO_LO, OUT_HILO_BUSY} !== {32'h1, 32'hF, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_commit: got hi=%h lo=%h busy=%b, expected hi=00000001 lo=0000000f busy=0",
                     OUT_HILO_HI, OUT_HILO_LO, OUT_HILO_BUSY);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, C_MULT, {$urandom, $urandom}, 32'h0);
        #1;
        tick();
        drive(1'b0, 12'h000, 64'h0, 32'h0);
        tick();
        tick();
        RST = 1'b1;
        #1;
        n_checks++;
        if ({OUT_HILO_BUSY, OUT_HILO_HI, OUT_HILO_LO, OUT_HILO_DIVZ} !== 66'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b hi=%h lo=%h divz=%b, expected all zero",
                     OUT_HILO_BUSY, OUT_HILO_HI, OUT_HILO_LO, OUT_HILO_DIVZ);
        end
        model_reset();
        RST = 1'b0;
        drive(1'b1, C_MFLO, 64'h0, 32'h0);
        #1;
        n_checks++;
        if ({OUT_HILO_STALL, OUT_HILO_32} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_mid_mflo: got stall=%b out=%h, expected stall=0 out=00000000", OUT_HILO_STALL, OUT_HILO_32);
        end
        tick();
    endtask

    task automatic test_random();
        int r;
        logic [31:0] dv;
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 9);
            dv = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            case (r)
                0, 1:    drive(1'b1, C_MULT, {$urandom, $urandom}, dv);
                2:       drive(1'b1, C_DIV, {$urandom, $urandom}, dv);
                3, 4:    drive(1'b1, C_MFHI, {$urandom, $urandom}, dv);
                5, 6:    drive(1'b1, C_MFLO, {$urandom, $urandom}, dv);
                7:       drive(1'b1, 12'($urandom), {$urandom, $urandom}, dv);
                8:       drive(1'b0, C_MULT, {$urandom, $urandom}, dv);
                default: drive(1'b0, C_MFHI, {$urandom, $urandom}, dv);
            endcase
            #1;
            predict();
            n_checks++;
            if ({OUT_HILO_STALL, OUT_HILO_BUSY, OUT_HILO_32} !== {exp_stall, exp_busy, exp_out}) begin
                n_fail++;
                $display("FAIL rand_out%0d: got stall=%b busy=%b out=%h, expected stall=%b busy=%b out=%h",
                         i, OUT_HILO_STALL, OUT_HILO_BUSY, OUT_HILO_32, exp_stall, exp_busy, exp_out);
            end
            n_checks++;
            if ({OUT_HILO_HI, OUT_HILO_LO, OUT_HILO_DIVZ} !== {m_hi, m_lo, m_divz}) begin
                n_fail++;
                $display("FAIL rand_arch%0d: got hi=%h lo=%h divz=%b, expected hi=%h lo=%h divz=%b",
                         i, OUT_HILO_HI, OUT_HILO_LO, OUT_HILO_DIVZ, m_hi, m_lo, m_divz);
            end
            tick();
        end
    endtask

    initial begin
        t_edge = 0;
        model_reset();
        RST = 1'b1;
        drive(1'b0, 12'h000, 64'h0, 32'h0);
        test_reset();
        test_mult_read();
        test_div();
        test_divz();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Multi-cycle HI/LO result unit at the consumer end of the ALU's 64-bit result path. It decodes the 12-bit ALU control word of the instruction in EX and captures `IN_HILO_ALU64` for MULTIPLY and DIVIDE. It models multiplier/divider latency with a busy counter, commits the result to the architectural HI/LO registers, and serves MOVE FROM HI/LO reads. It raises a pipeline stall on any HI/LO hazard.

## Interface
- `MUL_LAT`, default 4: cycles from MULTIPLY accept to HI/LO commit (legal 1..255).
- `DIV_LAT`, default 12: cycles from DIVIDE accept to HI/LO commit (legal 1..255).

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `IN_HILO_VALID` in 1: EX slot holds a real instruction (not a bubble).
- `IN_HILO_CTRL` in 12: `{opcode, funct}` control word of the EX instruction.
- `IN_HILO_ALU64` in 64: ALU 64-bit result.
  - MULTIPLY: product.
  - DIVIDE: `{remainder, quotient}`.
- `IN_HILO_DIVISOR` in 32: second DIVIDE operand, used for zero detection.
- `OUT_HILO_32` out 32: MOVE FROM HI/LO read data.
- `OUT_HILO_STALL` out 1: hold EX and earlier stages this cycle.
- `OUT_HILO_BUSY` out 1: an operation is in flight.
- `OUT_HILO_HI` out 32: architectural HI.
- `OUT_HILO_LO` out 32: architectural LO.
- `OUT_HILO_DIVZ` out 1: sticky divide-by-zero flag.

## Operation
- Decoded codes:
  - MULT `12'h0D8`
  - DIV `12'h0DA`
  - MFHI `12'h0D0`
  - MFLO `12'h0D2`
- All other codes are ignored: no stall, `OUT_HILO_32` = 0.
- "Op" means `IN_HILO_VALID` is high and `IN_HILO_CTRL` matches a decoded code.
- States:
  - IDLE
  - BUSY, with an 8-bit `cnt` and a 64-bit `pending` register.
- IDLE, MULT/DIV op:
  - Accept.
  - `pending <= IN_HILO_ALU64`.
  - `cnt <=` `MUL_LAT` or `DIV_LAT`.
  - Go to BUSY.
  - No stall.
- DIV with `IN_HILO_DIVISOR == 0`:
  - Not accepted; HI/LO untouched, state stays IDLE.
  - `OUT_HILO_DIVZ <= 1`. The flag is cleared only by `RST`.
- BUSY:
  - `cnt` decrements each edge.
  - At the edge where `cnt == 1`: `HI <= pending[63:32]`, `LO <= pending[31:0]`, go to IDLE.
- Reads:
  - MFHI/MFLO in IDLE: `OUT_HILO_32` = HI/LO combinationally, no stall.
  - MFHI/MFLO in BUSY: `OUT_HILO_STALL = 1`, `OUT_HILO_32` = 0.
  - Exception: see Configuration.
- MULT/DIV op in BUSY: stall. There is no overlap or queueing. The op is accepted on the first IDLE cycle.
- Mapping: LO = product low / quotient; HI = product high / remainder.
- `OUT_HILO_BUSY` = (state == BUSY).
- `OUT_HILO_STALL` is combinational from state, `cnt` and inputs. It is never asserted without an op.

## Timing
- Reset (asynchronous, immediate) sets:
  - state IDLE, `cnt` = 0, `pending` = 0.
  - HI = LO = 0, `OUT_HILO_DIVZ` = 0.
  - `OUT_HILO_BUSY` = 0, `OUT_HILO_STALL` = 0 (absent op), `OUT_HILO_32` = 0.
- Accept at edge E: BUSY during cycles E..E+LAT-1. HI/LO are visible after edge E+LAT.
- `LAT = 1`: commit at the first edge after accept; BUSY lasts one cycle.
- Commit edge with a new MULT/DIV presented:
  - That cycle still stalls.
  - Accept occurs at the next edge from IDLE.
  - Back-to-back issue spacing is LAT+1 cycles.
- Reset mid-operation:
  - `pending` is discarded and HI/LO = 0.
  - A stalled op must be re-presented.

## Configuration
- `HILO_BYPASS_EN` defined:
  - In BUSY with `cnt == 1`, MFHI/MFLO are not stalled.
  - `OUT_HILO_32` = `pending[63:32]` / `pending[31:0]`.
- `HILO_BYPASS_EN` undefined:
  - Such reads stall through the commit edge.
  - They are served from HI/LO in the following IDLE cycle: one extra stall cycle.

## Test plan
- Reset, then MFLO, MFHI ops in IDLE -> `OUT_HILO_32` = `0x00000000`, `OUT_HILO_STALL` = 0.
- `MUL_LAT = 4`, MULT with ALU64 = `0x00000002_00000003`, then continuous MFHI:
  - Stall and BUSY for 4 cycles (3 with bypass).
  - Then `OUT_HILO_32` = `0x00000002`, LO = `0x00000003`.
- DIV of 17 by 5, ALU64 = `0x00000002_00000003`:
  - After 12 cycles LO = 3, HI = 2.
  - MFLO at cnt 5 -> stall.
- DIV with `IN_HILO_DIVISOR` = 0 -> `OUT_HILO_DIVZ` = 1, BUSY stays 0, HI/LO unchanged. The flag persists until `RST`.
- MULT followed immediately by MULT (`0x1_0000000F`) -> second stalls 4 cycles, accepted at E+5, HI = 1, LO = `0xF` after E+9.
- `RST` asserted at cnt 2 of a MULT -> BUSY = 0 asynchronously, HI = LO = 0, a subsequent MFLO returns 0 without stall.
